// File: rtl/seq_array_mult.sv
// rtl/seq_array_mult.sv - sequential shift-add array multiplier, one partial-product row per clock
// Unsigned or two's-complement operands, valid/ready on both sides, 2*WIDTH-bit product.
module seq_array_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            signed_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   product_q;

  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_d;
  logic            last_row;

  always_comb begin
    a_ext    = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    addend   = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    last_row = (cnt_q == CW'(WIDTH - 1));
    // The multiplier MSB carries negative weight in two's complement.
    acc_d    = (signed_q && last_row) ? (acc_q - addend) : (acc_q + addend);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            cnt_q    <= '0;
            acc_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_row) begin
            // Only the finished sum ever reaches the visible product.
            product_q <= acc_d;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_array_mult.sv
// tb/tb_seq_array_mult.sv - randomized self-checking bench for seq_array_mult at WIDTH 4 and 8
module tb_seq_array_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv4, ir4, s4, ov4, or4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic       iv8, ir8, s8, ov8, or8, busy8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;

  seq_array_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(s4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
  );

  seq_array_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(s8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );

  // Reference: integer multiply of the interpreted operands, reduced mod 2^(2w).
  function automatic longint ref_mult(input int w, input longint av, input longint bv, input bit s);
    longint x, y, m;
    x = av;
    y = bv;
    if (s && av[w-1]) x = av - (longint'(1) << w);
    if (s && bv[w-1]) y = bv - (longint'(1) << w);
    m = (longint'(1) << (2 * w)) - 1;
    return (x * y) & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op4(input logic [3:0] av, input logic [3:0] bv, input bit sv,
                        output logic [7:0] p, output int lat, output bit ok);
    int w = 0;
    a4 = av; b4 = bv; s4 = sv; iv4 = 1'b1;
    while (!ir4 && w < 20) begin tick(); w++; end
    tick();
    lat = 0;
    while (!ov4 && lat < 40) begin
      a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom); iv4 = 1'($urandom);
      tick();
      lat++;
    end
    iv4 = 1'b0;
    p = p4;
    ok = ov4 && (w < 20);
  endtask

  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input bit sv,
                        output logic [15:0] p, output int lat, output bit ok);
    int w = 0;
    a8 = av; b8 = bv; s8 = sv; iv8 = 1'b1;
    while (!ir8 && w < 20) begin tick(); w++; end
    tick();
    lat = 0;
    while (!ov8 && lat < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); iv8 = 1'($urandom);
      tick();
      lat++;
    end
    iv8 = 1'b0;
    p = p8;
    ok = ov8 && (w < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv4 = 0; a4 = 0; b4 = 0; s4 = 0; or4 = 0;
    iv8 = 0; a8 = 0; b8 = 0; s8 = 0; or8 = 0;
    tick(); tick();
    checks++; if (ir4 !== 1'b0) begin errors++; $display("FAIL reset_in_ready4: got %b expected 0", ir4); end
    checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL reset_in_ready8: got %b expected 0", ir8); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy4); end
    checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL reset_product: got %h expected 00", p4); end
    rst = 1'b0;
    #1;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready4: got %b expected 1", ir4); end
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready8: got %b expected 1", ir8); end
  endtask

  task automatic test_unsigned_max();
    logic [7:0] p; int lat; bit ok;
    or4 = 1'b1;
    do_op4(4'hF, 4'hF, 1'b0, p, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL umax_done: got out_valid %b expected 1", ov4); end
    checks++; if (lat != 4) begin errors++; $display("FAIL umax_latency: got %0d expected 4", lat); end
    checks++; if (p !== 8'hE1) begin errors++; $display("FAIL umax_product: got %h expected e1", p); end
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL umax_busy_done: got %b expected 1", busy4); end
    tick();
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL umax_ready_again: got %b expected 1", ir4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL umax_valid_drop: got %b expected 0", ov4); end
    checks++; if (p4 !== 8'hE1) begin errors++; $display("FAIL umax_hold_idle: got %h expected e1", p4); end
  endtask

  task automatic test_signed_corners();
    int ta [6] = '{8, 8, 15, 8, 0, 6};
    int tb_ [6] = '{8, 7, 15, 15, 9, 0};
    int ts [6] = '{1, 1, 1, 0, 1, 0};
    int te [6] = '{8'h40, 8'hC8, 8'h01, 8'h78, 8'h00, 8'h00};
    logic [7:0] p; int lat; bit ok;
    or4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_op4(4'(ta[i]), 4'(tb_[i]), ts[i] != 0, p, lat, ok);
      checks++;
      if (!ok || p !== 8'(te[i])) begin
        errors++;
        $display("FAIL corner_%0d: got %h (valid %b) expected %h", i, p, ok, 8'(te[i]));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] p; int lat; bit ok; int extra = 0;
    or4 = 1'b0;
    do_op4(4'd5, 4'd3, 1'b0, p, lat, ok);
    checks++; if (!ok || p !== 8'd15) begin errors++; $display("FAIL bp_product: got %h expected 0f", p); end
    for (int i = 0; i < 10; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom); iv4 = 1'($urandom);
      tick();
      checks++; if (p4 !== 8'd15) begin errors++; $display("FAIL bp_hold_%0d: got %h expected 0f", i, p4); end
      checks++; if (ir4 !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 0", i, ir4); end
      checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %b expected 1", i, ov4); end
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    tick();
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", ov4); end
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", ir4); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ov4) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL bp_single_handshake: got %0d extra outputs expected 0", extra); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] p; int lat; bit ok;
    or4 = 1'b1;
    a4 = 4'd7; b4 = 4'd9; s4 = 1'b0; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    tick(); tick();
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy4); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", ov4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy4); end
    checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL midrst_product: got %h expected 00", p4); end
    #1;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ir4); end
    do_op4(4'd7, 4'd9, 1'b0, p, lat, ok);
    checks++; if (!ok || p !== 8'd63 || lat != 4) begin errors++; $display("FAIL midrst_recover: got %h lat %0d expected 3f lat 4", p, lat); end
    tick();
  endtask

  task automatic test_exhaustive();
    logic [7:0] p; logic [7:0] exp; int lat; bit ok; int pre;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          iv4 = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          pre = int'($urandom_range(0, 1));
          or4 = (pre != 0);
          exp = 8'(ref_mult(4, longint'(a), longint'(b), s != 0));
          do_op4(4'(a), 4'(b), s != 0, p, lat, ok);
          checks++;
          if (!ok || p !== exp || lat != 4) begin
            errors++;
            $display("FAIL exh s%0d a%0d b%0d: got %h lat %0d expected %h lat 4", s, a, b, p, lat, exp);
          end
          if (pre == 0) begin
            repeat ($urandom_range(0, 2)) tick();
            or4 = 1'b1;
          end
          tick();
          or4 = 1'b0;
          checks++;
          if (ov4 !== 1'b0) begin errors++; $display("FAIL exh_one_output s%0d a%0d b%0d: got out_valid %b expected 0", s, a, b, ov4); end
        end
      end
    end
  endtask

  task automatic test_width8();
    logic [15:0] p; logic [15:0] exp; int lat; bit ok; logic [7:0] ra, rb; bit rs;
    or8 = 1'b1;
    do_op8(8'hFF, 8'hFF, 1'b0, p, lat, ok);
    checks++; if (!ok || p !== 16'hFE01) begin errors++; $display("FAIL w8_umax: got %h expected fe01", p); end
    checks++; if (lat != 8) begin errors++; $display("FAIL w8_latency: got %0d expected 8", lat); end
    tick();
    do_op8(8'h80, 8'h80, 1'b1, p, lat, ok);
    checks++; if (!ok || p !== 16'h4000) begin errors++; $display("FAIL w8_sminmin: got %h expected 4000", p); end
    tick();
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      exp = 16'(ref_mult(8, longint'(ra), longint'(rb), rs));
      do_op8(ra, rb, rs, p, lat, ok);
      checks++;
      if (!ok || p !== exp) begin errors++; $display("FAIL w8_rand_%0d: got %h expected %h", i, p, exp); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_backpressure();
    test_reset_mid_run();
    test_exhaustive();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
